mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the core's instruction-fetch port and its load/store port.
- Fixed-priority arbitration, data over fetch, with a starvation guard for fetch.
- Registered memory-side outputs, a one-cycle response pulse per transaction, and a watchdog that aborts transactions the memory never acknowledges.
- Sits between mips's pc/instr and aluout/writedata/readdata/memwrite ports and the shared memory; the core stalls until each valid pulse.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and load/store.
// Data wins over fetch, except when fetch has waited through MAX_DGRANTS consecutive data grants.
module mem_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned MAX_DGRANTS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(MAX_DGRANTS + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = data port, 0 = fetch port
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          err_q, err_d;
  logic          grant_data;
  logic [DW-1:0] rsp_data;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = if_valid_q;
    d_valid_d   = d_valid_q;
    err_d       = err_q;
    grant_data  = d_req && !(if_req && (starve_q == SW'(MAX_DGRANTS)));
    // Stores and timeouts return zero; only an acknowledged read carries memory data.
    rsp_data    = (mem_ready && !mem_we_q) ? mem_rdata : '0;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d   = StBusy;
          mem_req_d = 1'b1;
          tmo_d     = TW'(1);
          owner_d   = grant_data;
          if (grant_data) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != SW'(MAX_DGRANTS)) begin
              starve_d = starve_q + SW'(1);
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end
      StBusy: begin
        if (mem_ready || (tmo_q == TW'(TIMEOUT))) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          err_d     = !mem_ready;
          if (owner_q) begin
            d_rdata_d = rsp_data;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = rsp_data;
            if_valid_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StDone: begin
        state_d    = StIdle;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        tmo_d      = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      tmo_q       <= '0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level
// model of grants, latency, error flag and memory contents.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int MAXD    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_DGRANTS(MAXD)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;          // BUSY cycle in which memory acks; 0 = never
  int          busy_cnt;
  int          last_busy_len;
  int          model_starve = 0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  grant_t      grants [$];
  grant_t      cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory: acks in BUSY cycle `lat`, noise on ready/rdata otherwise.
  initial begin : responder
    mem_ready     = 1'b0;
    mem_rdata     = '0;
    busy_cnt      = 0;
    last_busy_len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          cap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
          grants.push_back(cap);
        end else begin
          chk("mem_addr_stable", 64'(mem_addr), 64'(cap.addr));
          chk("mem_we_wdata_stable", 64'({mem_we, mem_wdata}), 64'({cap.we, cap.wdata}));
        end
        if (lat != 0 && busy_cnt == lat) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : init_word(mem_addr);
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (busy_cnt != 0) last_busy_len = busy_cnt;
        busy_cnt  = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  task automatic start();
    @(posedge clk);
    #1;
  endtask

  // Waits for a completion pulse; k = 1 is the cycle in which the request is first seen in IDLE.
  task automatic await_valid(output int k, output logic iv, output logic dv, output logic e,
                             output logic [31:0] ir, output logic [31:0] dr);
    k = 0; iv = 0; dv = 0; e = 0; ir = '0; dr = '0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        k = i; iv = if_valid; dv = d_valid; e = err; ir = if_rdata; dr = d_rdata;
        break;
      end
    end
    if (iv) if_req = 1'b0;
    if (dv) d_req = 1'b0;
  endtask

  task automatic grant_model(input logic ifr, input logic dr, output logic is_data);
    if (dr && !(ifr && model_starve == MAXD)) begin
      is_data      = 1'b1;
      model_starve = ifr ? ((model_starve < MAXD) ? model_starve + 1 : MAXD) : 0;
    end else begin
      is_data      = 1'b0;
      model_starve = 0;
    end
  endtask

  task automatic expect_txn(input string tag, input logic exp_data, input logic [31:0] addr,
                            input logic we, input logic [31:0] wdata, input int l,
                            output logic obs_data);
    int          k;
    logic        iv, dv, e, to;
    logic [31:0] ir, dr, exp_rd, obs_rd;
    grant_t      g;
    to     = (l == 0) || (l > TIMEOUT);
    exp_rd = (to || we) ? 32'h0 : ref_rd(addr);
    await_valid(k, iv, dv, e, ir, dr);
    obs_data = dv;
    chk({tag, "_seen"}, 64'(iv | dv), 64'(1));
    chk({tag, "_owner"}, 64'({iv, dv}), exp_data ? 64'(2'b01) : 64'(2'b10));
    chk({tag, "_lat"}, 64'(k - 1), to ? 64'(TIMEOUT + 1) : 64'(l + 1));
    chk({tag, "_err"}, 64'(e), 64'(to));
    obs_rd = exp_data ? dr : ir;
    chk({tag, "_rdata"}, 64'(obs_rd), 64'(exp_rd));
    chk({tag, "_grants"}, 64'(grants.size()), 64'(1));
    if (grants.size() != 0) begin
      g = grants.pop_front();
      chk({tag, "_mem_addr"}, 64'(g.addr), 64'(addr));
      chk({tag, "_mem_we_wdata"}, 64'({g.we, g.wdata}), 64'({we, wdata}));
    end
    if (!to && we) ref_mem[addr] = wdata;
  endtask

  task automatic serve(input string tag, input int l);
    logic isd, od;
    lat = l;
    for (int n = 0; n < 2 && (if_req || d_req); n++) begin
      grant_model(if_req, d_req, isd);
      if (isd) expect_txn(tag, 1'b1, d_addr, d_we, d_wdata, l, od);
      else     expect_txn(tag, 1'b0, if_addr, 1'b0, 32'h0, l, od);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic       isd, od;
    logic [9:0] seq;
    int         lats [7] = '{1, 2, 3, 5, 16, 0, 18};
    int         r;

    reset = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_model[32'h40] = 32'h2008_0005;
    ref_mem[32'h40]   = 32'h2008_0005;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_valids_err", 64'({if_valid, d_valid, err}), 64'(0));
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    start();
    reset = 1'b1;
    grants.delete();

    // Single fetch
    start();
    if_req = 1; if_addr = 32'h40;
    serve("fetch1", 1);
    @(negedge clk);
    chk("fetch1_hold", 64'(if_rdata), 64'(32'h2008_0005));
    chk("fetch1_pulse", 64'({if_valid, err}), 64'(0));

    // Simultaneous requests: store first, then fetch
    start();
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'hDEAD_BEEF;
    serve("simul", 1);
    start();
    d_req = 1; d_we = 0; d_addr = 32'h54;
    serve("readback", 2);

    // Starvation guard: fetch held, data re-raised after every completion
    start();
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h100;
    lat = 1;
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      grant_model(if_req, d_req, isd);
      if (isd) expect_txn("starve", 1'b1, d_addr, d_we, d_wdata, 1, od);
      else     expect_txn("starve", 1'b0, if_addr, 1'b0, 32'h0, 1, od);
      seq[9-i] = od;
      if (i < 9) begin
        start();
        if_req = 1; d_req = 1; d_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
    end
    chk("starve_pattern", 64'(seq), 64'(10'b1111011110));
    serve("starve_drain", 1);

    // Timeout, then a normal transaction
    start();
    if_req = 1; if_addr = 32'h200;
    serve("tmo", 0);
    chk("tmo_busy_len", 64'(last_busy_len), 64'(TIMEOUT));
    start();
    d_req = 1; d_we = 0; d_addr = 32'h104;
    serve("after_tmo", 2);

    // Ready in the last allowed BUSY cycle
    start();
    d_req = 1; d_we = 0; d_addr = 32'h108;
    serve("tmo_edge", TIMEOUT);

    // Reset in the third BUSY cycle
    start();
    d_req = 1; d_we = 0; d_addr = 32'h10C;
    lat = 0;
    repeat (3) start();
    reset = 1'b0;
    start();
    chk("rst_busy_mem_req", 64'(mem_req), 64'(0));
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy_no_valid", 64'({if_valid, d_valid, err}), 64'(0));
    end
    start();
    reset = 1'b1;
    model_starve = 0;
    grants.delete();
    start();
    d_req = 1; d_we = 0; d_addr = 32'h10C;
    serve("rst_reissue", 2);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      start();
      r = $urandom_range(1, 3);
      if (r[0]) begin
        if_req = 1; if_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
      if (r[1]) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h100 + 32'(4 * $urandom_range(0, 7)); d_wdata = $urandom;
      end
      serve("rand", lats[$urandom_range(0, 6)]);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
